// File: rtl/jtag_bridge_param.sv
// FT245-to-JTAG/AS bridge: turns host bytes into registered pin updates and shift bursts, and returns captured data.
// Optional `JTAG_AS_MODE_EN enables the B_NCE/B_NCS pins and B_ASDO capture; the default build is JTAG-only.
module jtag_bridge_param #(
    parameter int TCK_DIV  = 1,
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       nRXF,
    input  logic       nTXE,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       nRD,
    output logic       WR,
    input  logic       B_TDO,
    input  logic       B_ASDO,
    output logic       B_TCK,
    output logic       B_TMS,
    output logic       B_TDI,
    output logic       B_NCE,
    output logic       B_NCS,
    output logic       B_OE,
    output logic       busy
);

    localparam logic [15:0] RD_LAST  = 16'(RD_PULSE - 1);
    localparam logic [15:0] WR_LAST  = 16'(WR_PULSE - 1);
    localparam logic [15:0] DIV_LAST = 16'(TCK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_STROBE, S_DECODE, S_BB_SAMPLE, S_SH_LOW,
        S_SH_HIGH, S_TX_WAIT, S_TX_SETUP, S_TX_STROBE, S_TX_HOLD
    } state_t;

    state_t      state_q;
    logic        rxf_s1_q, rxf_s2_q, txe_s1_q, txe_s2_q;
    logic [15:0] cnt_q;
    logic [7:0]  byte_q, sh_data_q, cap_q, tx_q, dout_q;
    logic [2:0]  bit_q;
    logic [5:0]  count_q;
    logic        rd_flag_q;
    logic        nrd_q, wr_q, doe_q;
    logic        tck_q, tms_q, tdi_q, oe_q;
    logic        cap_src_d;

`ifdef JTAG_AS_MODE_EN
    logic        nce_q, ncs_q;
    assign B_NCE     = nce_q;
    assign B_NCS     = ncs_q;
    assign cap_src_d = ncs_q ? B_TDO : B_ASDO;
`else
    assign B_NCE     = 1'b0;
    assign B_NCS     = 1'b1;
    assign cap_src_d = B_TDO;
`endif

    assign D_OUT = dout_q;
    assign D_OE  = doe_q;
    assign nRD   = nrd_q;
    assign WR    = wr_q;
    assign B_TCK = tck_q;
    assign B_TMS = tms_q;
    assign B_TDI = tdi_q;
    assign B_OE  = oe_q;
    assign busy  = (state_q != S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            rxf_s1_q  <= 1'b1;
            rxf_s2_q  <= 1'b1;
            txe_s1_q  <= 1'b1;
            txe_s2_q  <= 1'b1;
            cnt_q     <= '0;
            byte_q    <= '0;
            sh_data_q <= '0;
            cap_q     <= '0;
            tx_q      <= '0;
            dout_q    <= '0;
            bit_q     <= '0;
            count_q   <= '0;
            rd_flag_q <= 1'b0;
            nrd_q     <= 1'b1;
            wr_q      <= 1'b0;
            doe_q     <= 1'b0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            oe_q      <= 1'b0;
`ifdef JTAG_AS_MODE_EN
            nce_q     <= 1'b0;
            ncs_q     <= 1'b1;
`endif
        end else begin
            rxf_s1_q <= nRXF;
            rxf_s2_q <= rxf_s1_q;
            txe_s1_q <= nTXE;
            txe_s2_q <= txe_s1_q;
            case (state_q)
                S_IDLE: begin
                    if (!rxf_s2_q) begin
                        nrd_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_RD_STROBE;
                    end
                end
                S_RD_STROBE: begin
                    if (cnt_q == RD_LAST) begin
                        byte_q  <= D_IN;
                        nrd_q   <= 1'b1;
                        state_q <= S_DECODE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DECODE: begin
                    // A pending burst count means this byte is shift data, whatever its top bits are.
                    if (count_q != 6'd0) begin
                        sh_data_q <= byte_q;
                        bit_q     <= 3'd0;
                        cnt_q     <= '0;
                        tck_q     <= 1'b0;
                        tdi_q     <= byte_q[0];
                        state_q   <= S_SH_LOW;
                    end else if (!byte_q[7]) begin
                        tck_q   <= byte_q[0];
                        tms_q   <= byte_q[1];
`ifdef JTAG_AS_MODE_EN
                        nce_q   <= byte_q[2];
                        ncs_q   <= byte_q[3];
`endif
                        tdi_q   <= byte_q[4];
                        oe_q    <= byte_q[5];
                        state_q <= byte_q[6] ? S_BB_SAMPLE : S_IDLE;
                    end else begin
                        count_q   <= byte_q[5:0];
                        rd_flag_q <= byte_q[6];
                        state_q   <= S_IDLE;
                    end
                end
                S_BB_SAMPLE: begin
                    tx_q    <= {6'b0, B_ASDO, B_TDO};
                    state_q <= S_TX_WAIT;
                end
                S_SH_LOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        tck_q   <= 1'b1;
                        state_q <= S_SH_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_SH_HIGH: begin
                    if (cnt_q == 16'd0) begin
                        cap_q[bit_q] <= cap_src_d;
                    end
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        tck_q <= 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_q   <= bit_q + 3'd1;
                            tdi_q   <= sh_data_q[bit_q + 3'd1];
                            state_q <= S_SH_LOW;
                        end else begin
                            if (count_q != 6'd0) begin
                                count_q <= count_q - 6'd1;
                            end
                            // With TCK_DIV=1 bit 7 is captured on this same edge, so merge it in directly.
                            tx_q    <= (cnt_q == 16'd0) ? {cap_src_d, cap_q[6:0]} : cap_q;
                            state_q <= rd_flag_q ? S_TX_WAIT : S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_TX_WAIT: begin
                    if (!txe_s2_q) begin
                        dout_q  <= tx_q;
                        doe_q   <= 1'b1;
                        state_q <= S_TX_SETUP;
                    end
                end
                S_TX_SETUP: begin
                    wr_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_TX_STROBE;
                end
                S_TX_STROBE: begin
                    if (cnt_q == WR_LAST) begin
                        wr_q    <= 1'b0;
                        state_q <= S_TX_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_TX_HOLD: begin
                    doe_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_bridge_param.sv
// Directed bench for jtag_bridge_param: FT245 host model, pin/strobe monitor, table of bit-bang vectors plus burst sequences.
module tb_jtag_bridge_param;

    localparam int TCK_DIV  = 3;
    localparam int RD_PULSE = 2;
    localparam int WR_PULSE = 2;
`ifdef JTAG_AS_MODE_EN
    localparam bit AS = 1'b1;
`else
    localparam bit AS = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       nrxf = 1'b1;
    logic       ntxe = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] D_OUT;
    logic       D_OE, nRD, WR;
    logic       b_tdo, tdo_drv = 1'b0, asdo_drv = 1'b0, loop_en = 1'b0;
    logic       B_TCK, B_TMS, B_TDI, B_NCE, B_NCS, B_OE, busy;

    assign b_tdo = loop_en ? B_TDI : tdo_drv;

    always #5 CLK = ~CLK;

    jtag_bridge_param #(.TCK_DIV(TCK_DIV), .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE)) dut (
        .CLK(CLK), .RESET(RESET), .nRXF(nrxf), .nTXE(ntxe), .D_IN(d_in),
        .D_OUT(D_OUT), .D_OE(D_OE), .nRD(nRD), .WR(WR),
        .B_TDO(b_tdo), .B_ASDO(asdo_drv),
        .B_TCK(B_TCK), .B_TMS(B_TMS), .B_TDI(B_TDI), .B_NCE(B_NCE), .B_NCS(B_NCS), .B_OE(B_OE),
        .busy(busy)
    );

    int compared = 0;
    int failed = 0;

    logic [7:0] rxq[$];
    logic [7:0] wq[$];
    int tck_times[$];

    int cyc = 0, proto_err = 0, wr_count = 0, rd_low_total = 0;
    int rd_run = 0, last_rd_w = 0, wr_run = 0, last_wr_w = 0;
    int tck_rises = 0, tdi0_rises = 0, tck_run = 0, tck_hi_bad = 0;
    logic wr_prev = 1'b0, doe_prev = 1'b0, nrd_prev = 1'b1, tck_prev = 1'b0;

    function automatic logic [5:0] pins();
        return {B_OE, B_TDI, B_NCS, B_NCE, B_TMS, B_TCK};
    endfunction

    // FT245 receive side: nRXF rises when the read strobe starts, byte pops on nRD release.
    initial begin
        bit rd_seen = 0;
        int gap = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                nrxf = 1'b1; rd_seen = 0; gap = 0;
            end else if (!nRD) begin
                nrxf = 1'b1; rd_seen = 1;
            end else if (rd_seen) begin
                if (rxq.size() > 0) void'(rxq.pop_front());
                rd_seen = 0; gap = 3;
            end else if (gap > 0) begin
                gap--;
            end else begin
                nrxf = (rxq.size() == 0);
            end
            d_in = (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    // Strobe/pin monitor.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET) begin
                if (!nRD && WR) proto_err++;
                if (WR && !D_OE) proto_err++;
                if (WR && !wr_prev && !doe_prev) proto_err++;
                if (!WR && wr_prev && !D_OE) proto_err++;
            end
            if (WR && !wr_prev) begin wq.push_back(D_OUT); wr_count++; end
            if (WR) wr_run++; else if (wr_prev) begin last_wr_w = wr_run; wr_run = 0; end
            if (!nRD) begin rd_low_total++; rd_run++; end
            else if (!nrd_prev) begin last_rd_w = rd_run; rd_run = 0; end
            if (B_TCK && !tck_prev) begin
                tck_rises++; tck_times.push_back(cyc);
                if (!B_TDI) tdi0_rises++;
            end
            if (B_TCK) tck_run++;
            else if (tck_prev) begin if (tck_run != TCK_DIV) tck_hi_bad++; tck_run = 0; end
            wr_prev = WR; doe_prev = D_OE; nrd_prev = nRD; tck_prev = B_TCK;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while ((rxq.size() != 0 || busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) begin
            compared++; failed++;
            $display("FAIL %s_timeout: busy after %0d cycles, required idle", tag, n);
        end
        repeat (4) @(negedge CLK);
    endtask

    function automatic int pop_wr();
        if (wq.size() == 0) return 32'h100;
        return int'(wq.pop_front());
    endfunction

    typedef struct {
        logic [7:0] cmd;
        logic       tdo;
        logic       asdo;
        logic [5:0] exp_pins;
        logic [5:0] exp_pins_as;
        logic       wr_en;
        logic [7:0] wr_val;
    } bb_vec_t;

    bb_vec_t vecs[7];

    initial begin
        int w0, r0, t0, h0, rl0, n, bad;
        vecs[0] = '{8'h41, 1'b1, 1'b0, 6'b001001, 6'b000001, 1'b1, 8'h01};
        vecs[1] = '{8'h3F, 1'b0, 1'b0, 6'b111011, 6'b111111, 1'b0, 8'h00};
        vecs[2] = '{8'h62, 1'b0, 1'b1, 6'b101010, 6'b100010, 1'b1, 8'h02};
        vecs[3] = '{8'h10, 1'b0, 1'b0, 6'b011000, 6'b010000, 1'b0, 8'h00};
        vecs[4] = '{8'h55, 1'b1, 1'b1, 6'b011001, 6'b010101, 1'b1, 8'h03};
        vecs[5] = '{8'h08, 1'b0, 1'b0, 6'b001000, 6'b001000, 1'b0, 8'h00};
        vecs[6] = '{8'h40, 1'b0, 1'b0, 6'b001000, 6'b000000, 1'b1, 8'h00};

        // Reset state, during and after reset.
        repeat (3) @(negedge CLK);
        check("rst_strobes", int'({nRD, WR, D_OE}), 32'b100);
        check("rst_dout", int'(D_OUT), 0);
        check("rst_pins", int'(pins()), 32'b001000);
        check("rst_busy", int'(busy), 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_rst_idle", int'({busy, nRD, pins()}), 32'b01001000);

        // Bit-bang vectors.
        for (int i = 0; i < 7; i++) begin
            tdo_drv = vecs[i].tdo; asdo_drv = vecs[i].asdo;
            wq.delete(); w0 = wr_count;
            rxq.push_back(vecs[i].cmd);
            wait_done($sformatf("bb%0d", i));
            check($sformatf("bb%0d_pins cmd=%02h", i, vecs[i].cmd), int'(pins()),
                  int'(AS ? vecs[i].exp_pins_as : vecs[i].exp_pins));
            check($sformatf("bb%0d_writes", i), wr_count - w0, int'(vecs[i].wr_en));
            if (vecs[i].wr_en) check($sformatf("bb%0d_data", i), pop_wr(), int'(vecs[i].wr_val));
        end

        // Bit-bang latency and read strobe width.
        rxq.push_back(8'h00); wait_done("lat_pre");
        rxq.push_back(8'h02);
        n = 0;
        while (nRD && n < 200) begin @(negedge CLK); n++; end
        check("lat_nrd_seen", int'(nRD), 0);
        n = 0;
        while (!B_TMS && n < 20) begin @(negedge CLK); n++; end
        check("lat_nrd_to_pins", n, RD_PULSE + 1);
        wait_done("lat");
        check("nrd_width", last_rd_w, RD_PULSE);

        // Burst 0xC2 A5 3C, TDO looped to TDI.
        rxq.push_back(8'h2A); wait_done("sh_pre");
        loop_en = 1'b1; wq.delete(); tck_times.delete();
        w0 = wr_count; r0 = tck_rises; h0 = tck_hi_bad;
        rxq.push_back(8'hC2); rxq.push_back(8'hA5); rxq.push_back(8'h3C);
        wait_done("sh2");
        check("sh2_tck_pulses", tck_rises - r0, 16);
        bad = 0;
        if (tck_times.size() < 16) bad = 99;
        else for (int j = 0; j < 15; j++)
            if (j != 7 && tck_times[j+1] - tck_times[j] != 2 * TCK_DIV) bad++;
        check("sh2_tck_period", bad, 0);
        check("sh2_tck_high_width", tck_hi_bad - h0, 0);
        check("sh2_writes", wr_count - w0, 2);
        check("sh2_data0", pop_wr(), 32'hA5);
        check("sh2_data1", pop_wr(), 32'h3C);
        check("sh2_pins_held", int'(pins()), 32'b101010);
        loop_en = 1'b0;

        // Burst without read-back.
        w0 = wr_count; r0 = tck_rises; t0 = tdi0_rises;
        rxq.push_back(8'h81); rxq.push_back(8'hFF);
        wait_done("sh1");
        check("sh1_tck_pulses", tck_rises - r0, 8);
        check("sh1_tdi_low_at_rise", tdi0_rises - t0, 0);
        check("sh1_writes", wr_count - w0, 0);
        check("sh1_tdi_final", int'(B_TDI), 1);

        // Zero-length header, following byte is a command.
        r0 = tck_rises;
        rxq.push_back(8'h80); rxq.push_back(8'h03);
        wait_done("sh0");
        check("sh0_tck_pulses", tck_rises - r0, 1);
        check("sh0_next_cmd_pins", int'(pins()), AS ? 32'b000011 : 32'b001011);

        // nTXE held off; a command arriving meanwhile waits.
        ntxe = 1'b1; tdo_drv = 1'b1; asdo_drv = 1'b0;
        wq.delete(); w0 = wr_count;
        rxq.push_back(8'h41);
        n = 0;
        while (rxq.size() != 0 && n < 200) begin @(negedge CLK); n++; end
        rl0 = rd_low_total;
        rxq.push_back(8'h00);
        repeat (100) @(negedge CLK);
        check("txe_hold_writes", wr_count - w0, 0);
        check("txe_hold_nrd_low", rd_low_total - rl0, 0);
        check("txe_hold_busy", int'(busy), 1);
        check("txe_hold_rx_pending", rxq.size(), 1);
        ntxe = 1'b0;
        wait_done("txe");
        check("txe_writes", wr_count - w0, 1);
        check("txe_data", pop_wr(), 32'h01);
        check("wr_width", last_wr_w, WR_PULSE);
        check("txe_next_cmd_pins", int'(pins()), AS ? 32'b000000 : 32'b001000);

`ifdef JTAG_AS_MODE_EN
        // NCS=0 from previous command: capture follows ASDO.
        tdo_drv = 1'b0; asdo_drv = 1'b1; wq.delete(); w0 = wr_count;
        rxq.push_back(8'hC1); rxq.push_back(8'h00);
        wait_done("as");
        check("as_writes", wr_count - w0, 1);
        check("as_data", pop_wr(), 32'hFF);
`endif

        // Reset in the middle of the write strobe.
        tdo_drv = 1'b1; asdo_drv = 1'b0;
        rxq.push_back(8'h41);
        n = 0;
        while (!WR && n < 300) begin @(negedge CLK); n++; end
        check("rst_mid_wr_seen", int'(WR), 1);
        RESET = 1'b1;
        #1;
        check("rst_mid_strobes", int'({WR, D_OE, nRD}), 32'b001);
        check("rst_mid_ncs_busy", int'({B_NCS, busy}), 32'b10);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        wq.delete(); w0 = wr_count;
        rxq.push_back(8'h41);
        wait_done("rst_after");
        check("rst_after_writes", wr_count - w0, 1);
        check("rst_after_data", pop_wr(), 32'h01);
        check("rst_after_pins", int'(pins()), AS ? 32'b000001 : 32'b001001);

        check("strobe_protocol_errors", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/jtag_bridge_param.md
# jtag_bridge_param

Parametrised FT245-to-JTAG/AS bridge. It decodes the byte stream arriving from the FT245 FIFO into bit-bang pin updates and byte-shift bursts, and returns captured TDO/ASDO data to the host. Compared with the previous generation, it adds:
- a programmable TCK rate,
- programmable FT245 strobe widths,
- latched (glitch-free) pin outputs,
- correct per-byte read-back in shift mode.

It sits between the FT245 pad ring and the target JTAG/AS header.

## Interface
- TCK_DIV, 1: TCK half-period in CLK cycles (≥1).
- RD_PULSE, 2: nRD low width in CLK cycles (≥1); data sampled on last low cycle.
- WR_PULSE, 2: WR high width in CLK cycles (≥1).

- CLK  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- nRXF  in  1  FT245 receive data available (active-low); synchronised internally with 2 flops.
- nTXE  in  1  FT245 transmit space available (active-low); synchronised internally with 2 flops.
- D_IN  in  8  FT245 data bus, input side.
- D_OUT  out  8  FT245 data bus, output side.
- D_OE  out  1  drive enable for D; the tristate buffer lives at top level.
- nRD  out  1  FT245 read strobe.
- WR  out  1  FT245 write strobe.
- B_TDO  in  1  target TDO.
- B_ASDO  in  1  target AS DATAOUT.
- B_TCK, B_TMS, B_TDI, B_NCE, B_NCS, B_OE  out  1 each  target pins, all registered.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
Command byte format:
- bit7=0 (bit-bang): bits[5:0] → {B_OE, B_TDI, B_NCS, B_NCE, B_TMS, B_TCK}. bit6=1 requests read-back {6'b0, B_ASDO, B_TDO}.
- bit7=1 (shift header): N=bits[5:0] data bytes follow. bit6=1 returns one captured byte per shifted byte. N=0 → no-op, back to IDLE.

States:
- IDLE: wait for synced nRXF=0 → RD_STROBE.
- RD_STROBE: nRD=0 for RD_PULSE cycles, latch D_IN on the last cycle. Then DECODE, with nRD=1 for at least 1 cycle.
- DECODE: if shift count>0, the byte is data → SH_LOW with bit index 0. Otherwise:
  - bit-bang: register the pins, then go to BB_SAMPLE if bit6=1, else IDLE.
  - header: load the count and read flag, then IDLE.
- BB_SAMPLE: capture {B_ASDO, B_TDO} one cycle after the pins update → TX_WAIT.
- SH_LOW: B_TCK=0, B_TDI=data[i], held TCK_DIV cycles → SH_HIGH.
- SH_HIGH: B_TCK=1. Capture source is B_TDO if B_NCS=1, else B_ASDO; it is sampled on the first SH_HIGH cycle into capture[i]. Held TCK_DIV cycles. Then:
  - i<7: i+1 → SH_LOW.
  - i=7: B_TCK←0 and count−1, then TX_WAIT if the read flag is set, else IDLE.
- TX_WAIT: wait for synced nTXE=0 → TX_SETUP.
- TX_SETUP: D_OUT=byte, D_OE=1, 1 cycle → TX_STROBE.
- TX_STROBE: WR=1 for WR_PULSE cycles → TX_HOLD.
- TX_HOLD: WR=0, D_OE=1 for 1 cycle → IDLE.

B_TMS, B_NCE, B_NCS and B_OE hold their last bit-bang values through shift bursts. B_TDI holds the last shifted bit.

## Timing
- Reset values:
  - nRD=1, WR=0, D_OE=0, D_OUT=0.
  - B_TCK=0, B_TMS=0, B_TDI=0, B_NCE=0, B_NCS=1, B_OE=0.
  - busy=0, count=0, state=IDLE.
- Reset mid-operation (including during a strobe) forces these values asynchronously. Any partial byte or pending burst is discarded.
- Shift byte: 16·TCK_DIV cycles. TCK frequency = CLK/(2·TCK_DIV).
- Bit-bang pin latency: pins change at the DECODE edge, RD_PULSE+3 cycles after nRXF falls (2 sync + strobe + decode).
- nRD and WR are never asserted together. D_OE=1 strictly encloses WR=1 by at least 1 cycle on each side.
- If nRXF is low during TX_*, it is ignored until IDLE.
- Count wraps neither way: decrement only occurs when count>0.

## Configuration
- JTAG_AS_MODE_EN defined: B_NCE/B_NCS follow command bits, and capture selects B_ASDO when B_NCS=0.
- JTAG_AS_MODE_EN undefined: B_NCE=0 and B_NCS=1 always, bits 2–3 are ignored, capture is always B_TDO, and B_ASDO is unused.

## Test plan
- Reset held mid TX_STROBE → WR=0, D_OE=0, B_NCS=1, busy=0 immediately; next command processed normally.
- Bit-bang 0x41 with B_TDO=1, B_ASDO=0 → B_TCK=1, other pins 0; one write of 0x01.
- Header 0xC2, then data 0xA5, 0x3C, B_TDO looped to B_TDI, TCK_DIV=3 → 16 TCK pulses each 6 cycles; writes 0xA5 then 0x3C.
- Header 0x81, data 0xFF → 8 TCK pulses, TDI=1 throughout, no write, returns to IDLE.
- Header 0x80 → no TCK activity, next byte treated as command.
- nTXE held high 100 cycles in TX_WAIT → no WR, nRD stays 1. nTXE released → single write; with JTAG_AS_MODE_EN and B_NCS=0, captured data comes from B_ASDO.
